ysyx_25030093_muldiv: RTL and testbench
=======================================

// Module: ysyx_25030093_muldiv
// PURPOSE
//   Iterative RV32M multiply/divide unit: the multi-cycle companion to the single-cycle ALU.
//   Sits in the EXU beside the ALU. Accepts one op per valid/ready handshake.
//   Returns an XLEN result tagged with the destination register index.
//   Supports flush for a redirect or trap.
// PARAMETERS
//   XLEN   32  operand/result width (power of 2, >=8)
//   TAG_W  5   width of pass-through tag (rd index)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   flush      in   1      kill in-flight op
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept
//   in_op      in   3      mdu_op_t: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (funct3 order)
//   in_a       in   XLEN   rs1 data
//   in_b       in   XLEN   rs2 data
//   in_tag     in   TAG_W  rd index
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_data   out  XLEN   result
//   out_tag    out  TAG_W  tag of the result
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=1; out_valid=0; out_data=0; out_tag=0; counter=0.
//   - FSM IDLE->CALC on in_valid&in_ready (normal op).
//     CALC->DONE when counter reaches 0. DONE->IDLE on out_ready.
//     IDLE->DONE directly for special-case divides.
//   - in_ready=1 only in IDLE. No overlap: one op in flight.
//   - Operands are latched at accept; inputs are don't-care afterwards.
//   - Signed ops convert operands to magnitudes at accept and record the result sign.
//     MULHSU treats a as signed and b as unsigned.
//   - Multiply: shift-add, 1 bit/cycle, XLEN CALC cycles, 2*XLEN product.
//     MUL returns the low half; MULH* return the high half after sign fix.
//   - Divide: restoring, 1 bit/cycle, XLEN CALC cycles.
//     Quotient sign = sa^sb; remainder sign = sa.
//   - Latency from accept edge to out_valid: XLEN+1 cycles (mul and normal div).
//   - Special cases, out_valid 1 cycle after accept:
//     b==0: DIV/DIVU -> all-ones; REM/REMU -> a.
//     Signed overflow (a=MIN, b=-1): DIV -> MIN; REM -> 0.
//   - DONE: out_valid, out_data and out_tag stay stable until out_ready.
//     Backpressure of any length is legal.
//   - flush (any state): next cycle state=IDLE, out_valid=0, counter cleared.
//     An in_valid in the same cycle as flush is NOT accepted. Flush beats out_ready.
//   - Async reset mid-operation: immediately returns to the reset values above; no result is emitted.
//   - Arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). No exceptions are raised.
// CONFIGURATION
//   YSYX_25030093_MDU_FAST_MUL_EN
//   - Defined: MUL* use a single-cycle combinational XLEN+1 x XLEN+1 signed product.
//     IDLE->DONE with out_valid 1 cycle after accept. Divide is unchanged.
//   - Undefined: iterative multiplier as above (XLEN+1 latency).
// STRUCTURE
//   - Package ysyx_25030093_mdu_pkg:
//     mdu_op_t enum (3-bit, funct3 encoding)
//     mdu_state_t {IDLE,CALC,DONE}
//     helper function is_div(op)
//     helper function is_signed_a/b(op)
//   - One sub-module: ysyx_25030093_mdu_iter, the shared XLEN-step shift/add-sub datapath.
//     Mode input selects mul or div; exposes acc/quot registers.
//   - FSM, special-case detection and sign fix stay in this top.
// TESTING
//   - MUL a=7,b=-3 -> out_data=0xFFFFFFEB.
//     MULH a=0x80000000,b=0x80000000 -> 0x40000000.
//     Both at cycle 33 after accept (1 with FAST_MUL_EN).
//   - DIV a=-7,b=2 -> -3 (0xFFFFFFFD); REM a=-7,b=2 -> -1.
//     DIVU a=0xFFFFFFFF,b=16 -> 0x0FFFFFFF.
//   - DIVU/REM with b=0, a=0x1234 -> DIVU=0xFFFFFFFF, REM=0x1234.
//     DIV a=0x80000000,b=-1 -> 0x80000000; REM -> 0. All at cycle 1.
//   - Hold out_ready=0 for 10 cycles in DONE -> out_valid/out_data/out_tag stable, in_ready=0.
//     Then an out_ready pulse -> IDLE and in_ready=1 the next cycle.
//   - Assert flush at CALC cycle 5 with in_valid=1 the same cycle -> no out_valid ever for that op.
//     The new request is not accepted; it is accepted the cycle after.
//   - Deassert rst_n during CALC -> out_valid=0 and in_ready=1 immediately.
//     A random 1k-op stream checked against a reference model with random backpressure.

Source files
------------

// File: rtl/ysyx_25030093_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_mdu_pkg
//   Shared types and decode helpers for the RV32M multiply/divide unit.
//   - mdu_op_t    : 3-bit operation code in funct3 order
//   - mdu_state_t : control FSM state (IDLE / CALC / DONE)
//   - is_div, is_rem, is_signed_a, is_signed_b : operation decode helpers
// ---------------------------------------------------------------------------
package ysyx_25030093_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t IDLE = 2'd0;
    localparam mdu_state_t CALC = 2'd1;
    localparam mdu_state_t DONE = 2'd2;

    function automatic logic is_div(input mdu_op_t op);
        case (op)
            MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: is_div = 1'b1;
            default:                              is_div = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        case (op)
            MDU_REM, MDU_REMU: is_rem = 1'b1;
            default:           is_rem = 1'b0;
        endcase
    endfunction

    // MUL is treated as signed: its low half is identical either way.
    function automatic logic is_signed_a(input mdu_op_t op);
        case (op)
            MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: is_signed_a = 1'b1;
            default:                                         is_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input mdu_op_t op);
        case (op)
            MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: is_signed_b = 1'b1;
            default:                             is_signed_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030093_mdu_iter.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_mdu_iter
//   Shared 1-bit-per-step datapath on unsigned magnitudes.
//   mode=0: shift-add multiply, {acc,quot} ends as the 2*XLEN product.
//   mode=1: restoring divide, quot ends as quotient, acc as remainder.
//   The load cycle performs the first step on the incoming operands, so
//   XLEN steps complete after load plus XLEN-1 step cycles.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   srst            synchronous clear (flush)
//   load            capture a_mag/b_mag/mode and perform step 1
//   step            perform one further step on the held state
//   mode            0 = multiply, 1 = divide (sampled at load)
//   a_mag, b_mag    unsigned operand magnitudes
//   acc, quot       accumulator / quotient (low product) registers
// ---------------------------------------------------------------------------
module ysyx_25030093_mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            srst,
    input  logic            load,
    input  logic            step,
    input  logic            mode,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] quot
);

    logic [XLEN-1:0] acc_r, quot_r, b_r;
    logic            mode_r;
    logic [XLEN-1:0] cur_acc_s, cur_quot_s, cur_b_s;
    logic            cur_mode_s;
    logic [XLEN:0]   sum_s, shifted_s, diff_s;
    logic [XLEN-1:0] acc_nxt_s, quot_nxt_s;

    // Step operands come from the inputs on load, otherwise from the held state.
    always_comb begin
        if (load) begin
            cur_acc_s  = {XLEN{1'b0}};
            cur_quot_s = a_mag;
            cur_b_s    = b_mag;
            cur_mode_s = mode;
        end else begin
            cur_acc_s  = acc_r;
            cur_quot_s = quot_r;
            cur_b_s    = b_r;
            cur_mode_s = mode_r;
        end
    end

    // One multiply (add then shift right) or divide (shift left, trial subtract) step.
    always_comb begin
        sum_s     = {1'b0, cur_acc_s} + (cur_quot_s[0] ? {1'b0, cur_b_s} : {(XLEN+1){1'b0}});
        shifted_s = {cur_acc_s, cur_quot_s[XLEN-1]};
        diff_s    = shifted_s - {1'b0, cur_b_s};
        if (cur_mode_s) begin
            // Partial remainder is always < divisor, so diff MSB is the borrow.
            if (!diff_s[XLEN]) begin
                acc_nxt_s  = diff_s[XLEN-1:0];
                quot_nxt_s = {cur_quot_s[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_s  = shifted_s[XLEN-1:0];
                quot_nxt_s = {cur_quot_s[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s  = sum_s[XLEN:1];
            quot_nxt_s = {sum_s[0], cur_quot_s[XLEN-1:1]};
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {XLEN{1'b0}};
            quot_r <= {XLEN{1'b0}};
            b_r    <= {XLEN{1'b0}};
            mode_r <= 1'b0;
        end else if (srst) begin
            acc_r  <= {XLEN{1'b0}};
            quot_r <= {XLEN{1'b0}};
            b_r    <= {XLEN{1'b0}};
            mode_r <= 1'b0;
        end else if (load || step) begin
            acc_r  <= acc_nxt_s;
            quot_r <= quot_nxt_s;
            b_r    <= cur_b_s;
            mode_r <= cur_mode_s;
        end else begin
            acc_r  <= acc_r;
            quot_r <= quot_r;
            b_r    <= b_r;
            mode_r <= mode_r;
        end
    end

    assign acc  = acc_r;
    assign quot = quot_r;

endmodule

// File: rtl/ysyx_25030093_muldiv.sv
// ---------------------------------------------------------------------------
// ysyx_25030093_muldiv
//   Iterative RV32M multiply/divide unit with valid/ready handshakes.
//   One op in flight; result is returned with its rd tag.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   flush                  kill in-flight op (wins over everything)
//   in_valid/in_ready      request handshake; in_op (funct3), in_a, in_b, in_tag
//   out_valid/out_ready    result handshake; out_data, out_tag
// Build option:
//   YSYX_25030093_MDU_FAST_MUL_EN  single-cycle combinational multiply
// ---------------------------------------------------------------------------
module ysyx_25030093_muldiv
    import ysyx_25030093_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

    mdu_state_t       state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    mdu_op_t          op_r, op_nxt, op_s;
    logic             neg_q_r, neg_q_nxt, neg_r_r, neg_r_nxt;
    logic             out_valid_r, out_valid_nxt, in_ready_r;
    logic [XLEN-1:0]  out_data_r, out_data_nxt;
    logic [TAG_W-1:0] out_tag_r, out_tag_nxt;

    logic             a_neg_s, b_neg_s, special_s, load_s, step_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s, special_res_s, calc_res_s, fast_res_s;
    logic [XLEN-1:0]  acc_s, quot_s, quot_fix_s, rem_fix_s;
    logic [2*XLEN-1:0] prod_fix_s;

    assign op_s    = mdu_op_t'(in_op);
    assign a_neg_s = is_signed_a(op_s) & in_a[XLEN-1];
    assign b_neg_s = is_signed_b(op_s) & in_b[XLEN-1];
    assign a_mag_s = a_neg_s ? ({XLEN{1'b0}} - in_a) : in_a;
    assign b_mag_s = b_neg_s ? ({XLEN{1'b0}} - in_b) : in_b;

    // Divide-by-zero and signed overflow bypass the iterative datapath.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
        if (is_div(op_s) && (in_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = is_rem(op_s) ? in_a : ONES;
        end else if (is_div(op_s) && is_signed_a(op_s) && (in_a == MIN_VAL) && (in_b == ONES)) begin
            special_s     = 1'b1;
            special_res_s = is_rem(op_s) ? {XLEN{1'b0}} : MIN_VAL;
        end else begin
            special_s     = 1'b0;
            special_res_s = {XLEN{1'b0}};
        end
    end

`ifdef YSYX_25030093_MDU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    logic [2*XLEN-1:0] fa_s, fb_s, fp_s;
    // Sign-extending both operands lets one modulo-2^(2*XLEN) product serve every MUL*.
    assign fa_s       = {{XLEN{a_neg_s}}, in_a};
    assign fb_s       = {{XLEN{b_neg_s}}, in_b};
    assign fp_s       = fa_s * fb_s;
    assign fast_res_s = (op_s == MDU_MUL) ? fp_s[XLEN-1:0] : fp_s[2*XLEN-1:XLEN];
`else
    localparam logic FAST_MUL = 1'b0;
    assign fast_res_s = {XLEN{1'b0}};
`endif

    ysyx_25030093_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (flush),
        .load  (load_s),
        .step  (step_s),
        .mode  (is_div(op_s)),
        .a_mag (a_mag_s),
        .b_mag (b_mag_s),
        .acc   (acc_s),
        .quot  (quot_s)
    );

    // Sign fix of the magnitude result recorded at accept.
    always_comb begin
        prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - {acc_s, quot_s}) : {acc_s, quot_s};
        quot_fix_s = neg_q_r ? ({XLEN{1'b0}} - quot_s) : quot_s;
        rem_fix_s  = neg_r_r ? ({XLEN{1'b0}} - acc_s) : acc_s;
        case (op_r)
            MDU_MUL:                        calc_res_s = prod_fix_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              calc_res_s = quot_fix_s;
            MDU_REM, MDU_REMU:              calc_res_s = rem_fix_s;
            default:                        calc_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM next-state and output-register next values.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        op_nxt        = op_r;
        neg_q_nxt     = neg_q_r;
        neg_r_nxt     = neg_r_r;
        out_valid_nxt = out_valid_r;
        out_data_nxt  = out_data_r;
        out_tag_nxt   = out_tag_r;
        load_s        = 1'b0;
        step_s        = 1'b0;
        if (flush) begin
            state_nxt     = IDLE;
            cnt_nxt       = {CNT_W{1'b0}};
            out_valid_nxt = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_nxt      = op_s;
                        out_tag_nxt = in_tag;
                        neg_q_nxt   = a_neg_s ^ b_neg_s;
                        neg_r_nxt   = a_neg_s;
                        if (special_s) begin
                            state_nxt     = DONE;
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = special_res_s;
                        end else if (FAST_MUL && !is_div(op_s)) begin
                            state_nxt     = DONE;
                            out_valid_nxt = 1'b1;
                            out_data_nxt  = fast_res_s;
                        end else begin
                            // Load performs step 1; XLEN-1 further steps remain.
                            state_nxt = CALC;
                            cnt_nxt   = CNT_W'(XLEN-1);
                            load_s    = 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = calc_res_s;
                    end else begin
                        step_s  = 1'b1;
                        cnt_nxt = cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    cnt_nxt       = {CNT_W{1'b0}};
                    out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= MDU_MUL;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {XLEN{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            op_r        <= op_nxt;
            neg_q_r     <= neg_q_nxt;
            neg_r_r     <= neg_r_nxt;
            out_valid_r <= out_valid_nxt;
            out_data_r  <= out_data_nxt;
            out_tag_r   <= out_tag_nxt;
            in_ready_r  <= (state_nxt == IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_ysyx_25030093_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25030093_muldiv
//   Scoreboard bench for the multiply/divide unit. Expected results are
//   pushed at issue time; an independent monitor pops and compares on every
//   output handshake. Expected values come from integer arithmetic on
//   64-bit/32-bit SystemVerilog types.
// ---------------------------------------------------------------------------
module tb_ysyx_25030093_muldiv;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef YSYX_25030093_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a, in_b, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;     // 0: out_ready = rdy_force, 1: random backpressure
    logic rdy_force = 1'b1;

    ysyx_25030093_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // out_ready changes just after the rising edge so it is stable at negedge sampling
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = rdy_force;
        end
    end

    // Reference model: RV32M semantics with wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              ia, ib, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = ia / ib; return r;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = ia % ib; return r;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got data=%h tag=%0d", out_data, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL result got data=%h tag=%0d exp data=%h tag=%0d",
                             out_data, out_tag, e.data, e.tag);
                end
            end
        end
    end

    // Issue one request; called at a negedge, returns at the negedge after accept.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] expv, input bit push);
        int w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 exp in_ready=1");
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        if (push) exp_q.push_back({expv, tag});
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'($urandom);
    endtask

    // Wait for out_valid counting cycles from the accept cycle, then check latency.
    task automatic wait_valid(input string name, input int exp_lat);
        int cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc, exp_lat);
    endtask

    task automatic lat_test(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag,
                            input logic [31:0] expv, input int exp_lat);
        send(op, a, b, tag, expv, 1'b1);
        wait_valid({name, "_lat"}, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_op = 3'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values and latencies
        lat_test("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT);
        lat_test("mulh",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000, MUL_LAT);
        lat_test("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         5'd3, 32'hFFFF_FFFD, DIV_LAT);
        lat_test("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         5'd4, 32'hFFFF_FFFF, DIV_LAT);
        lat_test("divu",     3'd5, 32'hFFFF_FFFF,  32'd16,        5'd5, 32'h0FFF_FFFF, DIV_LAT);
        lat_test("divu_b0",  3'd5, 32'h0000_1234,  32'd0,         5'd6, 32'hFFFF_FFFF, SPC_LAT);
        lat_test("rem_b0",   3'd6, 32'h0000_1234,  32'd0,         5'd7, 32'h0000_1234, SPC_LAT);
        lat_test("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 32'h8000_0000, SPC_LAT);
        lat_test("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 32'd0,         SPC_LAT);

        // Backpressure: result held stable for 10 cycles
        rdy_force = 1'b0;
        @(negedge clk);
        send(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
        wait_valid("stall_lat", MUL_LAT);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_data",     out_data,       32'hFFFF_FFEB);
            check("stall_tag",      32'(out_tag),   32'd5);
            check("stall_in_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        rdy_force = 1'b0;
        @(negedge clk);
        check("release_in_ready",  32'(in_ready),  32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        rdy_force = 1'b1;
        @(negedge clk);

        // Flush at CALC cycle 5 with a competing request
        send(3'd5, $urandom, 32'd3, 5'd1, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        in_op = 3'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd9;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready",  32'(in_ready),  32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        exp_q.push_back({32'd12, 5'd9});
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("after_flush_lat", MUL_LAT);
        @(negedge clk);

        // Asynchronous reset during CALC
        send(3'd4, 32'd100, 32'd7, 5'd3, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_data",  out_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("directed_drain", 32'(exp_q.size()), 32'd0);

        // Random stream with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            send(op, a, b, 5'($urandom_range(0, 31)), ref_model(op, a, b), 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        begin
            int w = 0;
            while (exp_q.size() != 0 && w < 500) begin
                @(negedge clk);
                w++;
            end
        end
        check("random_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
